// File: rtl/multu_hilo_if.sv
// Multiply/HI-LO request bus between the pipeline and multu_hilo.
//   master : pipeline side; drives requests, operands' product and write data
//   slave  : multu_hilo side; returns mul_go, busy, stall, rdata, hi, lo
// Signals:
//   issue_mul           multiply issue request
//   product [2W-1:0]    multiplier product register
//   mthi/mtlo, wdata    HI/LO write requests and data
//   mfhi/mflo           HI/LO read requests
//   mul_go              one-cycle doMult/load pulse to the multiplier
//   busy, stall         in-flight flag and request hold-off
//   rdata, hi, lo       read data and architectural HI/LO
interface multu_hilo_if #(
  parameter int unsigned WIDTH = 32
);
  logic                   issue_mul;
  logic [2*WIDTH-1:0]     product;
  logic                   mthi;
  logic                   mtlo;
  logic [WIDTH-1:0]       wdata;
  logic                   mfhi;
  logic                   mflo;
  logic                   mul_go;
  logic                   busy;
  logic                   stall;
  logic [WIDTH-1:0]       rdata;
  logic [WIDTH-1:0]       hi;
  logic [WIDTH-1:0]       lo;

  modport master (
    output issue_mul, product, mthi, mtlo, wdata, mfhi, mflo,
    input  mul_go, busy, stall, rdata, hi, lo
  );

  modport slave (
    input  issue_mul, product, mthi, mtlo, wdata, mfhi, mflo,
    output mul_go, busy, stall, rdata, hi, lo
  );
endinterface

// File: rtl/multu_hilo.sv
// Sequencer and HI/LO owner for a shift-add unsigned multiplier that has no
// done flag. A multiply issue pulses mul_go, waits out the multiplier's fixed
// latency, then captures the 64-bit product into HI/LO. mthi/mtlo/mfhi/mflo
// are served while idle; every request is stalled while a multiply is in flight.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : multu_hilo_if.slave (requests in; mul_go/busy/stall/rdata/hi/lo out)
// Parameters:
//   WIDTH      : operand and HI/LO width, product is 2*WIDTH
//   MUL_CYCLES : clocks from the mul_go pulse until the product is final (>=1)
module multu_hilo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  multu_hilo_if.slave bus
);

  localparam int unsigned CW = 32'($clog2(MUL_CYCLES)) + 32'd1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RUN     = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;
  logic [WIDTH-1:0]  w_hi_nxt;
  logic [WIDTH-1:0]  w_lo_nxt;
  logic              r_mul_go;
  logic              r_busy;
  logic              w_mul_go_nxt;
  logic              w_busy_nxt;
  logic              w_any_req;
  logic [WIDTH-1:0]  w_rdata;

  // State, counter and architectural register updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mul_go <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_mul_go <= w_mul_go_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;

    unique case (r_state)
      S_IDLE: begin
        // Writes and issue may coincide; the later capture overwrites HI/LO.
        if (bus.mthi) w_hi_nxt = bus.wdata;
        if (bus.mtlo) w_lo_nxt = bus.wdata;
        if (bus.issue_mul) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_count_nxt = '0;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Hold at the last value so the counter never exceeds MUL_CYCLES-1.
        if (r_count == LAST_COUNT) begin
          w_state_nxt = S_CAPTURE;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      S_CAPTURE: begin
        w_hi_nxt    = bus.product[2*WIDTH-1:WIDTH];
        w_lo_nxt    = bus.product[WIDTH-1:0];
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Registered outputs are decoded from the next state so they line up
    // with the state they describe.
    w_mul_go_nxt = (w_state_nxt == S_LOAD);
    w_busy_nxt   = (w_state_nxt != S_IDLE);
  end

  // Read mux: pre-edge HI/LO, mfhi wins, zero while busy.
  always_comb begin
    w_rdata = '0;
    if (!r_busy) begin
      if (bus.mfhi) begin
        w_rdata = r_hi;
      end else if (bus.mflo) begin
        w_rdata = r_lo;
      end
    end
  end

  assign w_any_req = bus.issue_mul | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo;

  assign bus.mul_go = r_mul_go;
  assign bus.busy   = r_busy;
  assign bus.stall  = r_busy & w_any_req;
  assign bus.rdata  = w_rdata;
  assign bus.hi     = r_hi;
  assign bus.lo     = r_lo;

endmodule
